mem_port_initiator: RTL and testbench



---
 rtl/mem_port_pkg.sv | 7 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/mem_port_initiator.sv | 85 ++++++++
 tb/tb_mem_port_initiator.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// mem_port_pkg: op encoding and response latency helper shared by memory port clients
package mem_port_pkg;
   typedef enum logic {MEM_OP_READ = 1'b0, MEM_OP_WRITE = 1'b1} mem_op_e;
   function automatic int rspLatency(input int delay);
      return delay + 2;
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage, head read straight from the register array
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic do_push, do_pop;
   assign full_o = cnt_q == FULL;
   assign empty_o = cnt_q == '0;
   assign data_o = mem_q[rd_q];
   assign do_push = push_i && !full_o;
   assign do_pop = pop_i && !empty_o;
   // pointer wrap and occupancy next state
   always_comb begin
      wr_d = do_push ? (wr_q == LAST ? '0 : wr_q + 1'b1) : wr_q;
      rd_d = do_pop ? (rd_q == LAST ? '0 : rd_q + 1'b1) : rd_q;
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
   end
   // storage, pointers and count; reset clears contents so the head reads zero
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
         if (do_push) mem_q[wr_q] <= data_i;
      end
   end
endmodule

// File: rtl/mem_port_initiator.sv
// mem_port_initiator: valid/ready requests to a fixed-latency memory port, in-order responses
// Option MEM_PORT_INITIATOR_WRACK_EN: writes return the pre-write word as a response.
module mem_port_initiator
   import mem_port_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int LENGTH = 32,
   parameter int DELAY = 1,
   parameter int RSP_DEPTH = 4,
   localparam int AW = $clog2(LENGTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             reqValid_i,
   output logic             reqReady_o,
   input  logic             reqWr_i,
   input  logic [AW-1:0]    reqAddr_i,
   input  logic [WIDTH-1:0] reqData_i,
   output logic             rspValid_o,
   input  logic             rspReady_i,
   output logic [WIDTH-1:0] rspData_o,
   output logic             memEn_o,
   output logic             memWr_o,
   output logic [AW-1:0]    memAddr_o,
   output logic [WIDTH-1:0] memData_o,
   input  logic [WIDTH-1:0] memData_i
);
`ifdef MEM_PORT_INITIATOR_WRACK_EN
   localparam bit WRACK = 1'b1;
`else
   localparam bit WRACK = 1'b0;
`endif
   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam logic [CW-1:0] MAX_OUT = CW'(RSP_DEPTH);
   mem_op_e op;
   logic fire, rsp_op, rsp_fire, push, full, empty;
   logic [CW-1:0] out_q, out_d;
   logic [DELAY:0] track_q;
   logic memEn_q, memWr_q;
   logic [AW-1:0] memAddr_q;
   logic [WIDTH-1:0] memData_q;
   assign op = mem_op_e'(reqWr_i);
   assign reqReady_o = !rst_i && (out_q < MAX_OUT);
   assign fire = reqValid_i && reqReady_o;
   assign rsp_op = WRACK || op == MEM_OP_READ;
   assign rsp_fire = rspValid_o && rspReady_i;
   assign push = track_q[DELAY];
   assign rspValid_o = !empty;
   assign out_d = out_q + CW'(fire && rsp_op) - CW'(rsp_fire);
   assign memEn_o = memEn_q;
   assign memWr_o = memWr_q;
   assign memAddr_o = memAddr_q;
   assign memData_o = memData_q;
   // issue registers, response tracking pipeline and credit counter
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         memEn_q <= 1'b0;
         memWr_q <= 1'b0;
         memAddr_q <= '0;
         memData_q <= '0;
         track_q <= '0;
         out_q <= '0;
      end else begin
         memEn_q <= fire;
         memWr_q <= fire && op == MEM_OP_WRITE;
         if (fire) begin
            memAddr_q <= reqAddr_i;
            memData_q <= reqData_i;
         end
         track_q <= {track_q[DELAY-1:0], fire && rsp_op};
         out_q <= out_d;
         assert (!(push && full));
      end
   end
   sync_fifo #(.WIDTH(WIDTH), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push_i (push),
      .data_i (memData_i),
      .pop_i  (rsp_fire),
      .data_o (rspData_o),
      .full_o (full),
      .empty_o(empty)
   );
endmodule

// File: tb/tb_mem_port_initiator.sv
// tb_mem_port_initiator: directed checks on a DELAY=1 instance, scoreboarded random run on a DELAY=3 instance
module tb_mem_port_initiator;
   import mem_port_pkg::*;
   localparam int W = 16;
   localparam int L = 32;
   localparam int AW = 5;
   localparam int LAT_A = rspLatency(1);
`ifdef MEM_PORT_INITIATOR_WRACK_EN
   localparam bit WRACK = 1'b1;
`else
   localparam bit WRACK = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   int vectors = 0;
   int miscompares = 0;
   logic a_req_valid = 1'b0, a_req_wr = 1'b0, a_rsp_ready = 1'b0;
   logic [AW-1:0] a_req_addr = '0;
   logic [W-1:0] a_req_data = '0;
   logic a_req_ready, a_rsp_valid, a_mem_en, a_mem_wr;
   logic [AW-1:0] a_mem_addr;
   logic [W-1:0] a_rsp_data, a_mem_wdata, a_mem_rdata;
   logic b_req_valid = 1'b0, b_req_wr = 1'b0, b_rsp_ready = 1'b0;
   logic [AW-1:0] b_req_addr = '0;
   logic [W-1:0] b_req_data = '0;
   logic b_req_ready, b_rsp_valid, b_mem_en, b_mem_wr;
   logic [AW-1:0] b_mem_addr;
   logic [W-1:0] b_rsp_data, b_mem_wdata, b_p0, b_p1, b_p2;
   logic [W-1:0] mem_a [L];
   logic [W-1:0] mem_b [L];
   logic [W-1:0] shadow_b [L];

   function automatic logic [W-1:0] init_a(input int i);
      return i < 8 ? W'(i * 16'h11) : (i == 13 ? 16'hAAAA : W'(16'h1000 + i));
   endfunction
   function automatic logic [W-1:0] init_b(input int i);
      return W'(i * 16'h0123 + 16'h0F0F);
   endfunction

   mem_port_initiator #(.WIDTH(W), .LENGTH(L), .DELAY(1), .RSP_DEPTH(4)) dut_a (
      .clk_i(clk), .rst_i(rst), .reqValid_i(a_req_valid), .reqReady_o(a_req_ready),
      .reqWr_i(a_req_wr), .reqAddr_i(a_req_addr), .reqData_i(a_req_data),
      .rspValid_o(a_rsp_valid), .rspReady_i(a_rsp_ready), .rspData_o(a_rsp_data),
      .memEn_o(a_mem_en), .memWr_o(a_mem_wr), .memAddr_o(a_mem_addr),
      .memData_o(a_mem_wdata), .memData_i(a_mem_rdata));

   mem_port_initiator #(.WIDTH(W), .LENGTH(L), .DELAY(3), .RSP_DEPTH(5)) dut_b (
      .clk_i(clk), .rst_i(rst), .reqValid_i(b_req_valid), .reqReady_o(b_req_ready),
      .reqWr_i(b_req_wr), .reqAddr_i(b_req_addr), .reqData_i(b_req_data),
      .rspValid_o(b_rsp_valid), .rspReady_i(b_rsp_ready), .rspData_o(b_rsp_data),
      .memEn_o(b_mem_en), .memWr_o(b_mem_wr), .memAddr_o(b_mem_addr),
      .memData_o(b_mem_wdata), .memData_i(b_p2));

   // read-before-write memory, one cycle latency; contents reload while reset is held
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < L; i++) mem_a[i] <= init_a(i);
      end else if (a_mem_en) begin
         a_mem_rdata <= mem_a[a_mem_addr];
         if (a_mem_wr) mem_a[a_mem_addr] <= a_mem_wdata;
      end
   end

   // read-before-write memory, three cycle latency
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < L; i++) mem_b[i] <= init_b(i);
      end else if (b_mem_en) begin
         b_p0 <= mem_b[b_mem_addr];
         if (b_mem_wr) mem_b[b_mem_addr] <= b_mem_wdata;
      end
      b_p1 <= b_p0;
      b_p2 <= b_p1;
   end

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk); #1;
      vectors++;
      if (a_req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready_low: got %b expected 0", a_req_ready); end
      @(negedge clk); rst = 1'b0; #1;
      vectors++;
      if ({a_mem_en, a_mem_wr, a_mem_addr, a_mem_wdata, a_rsp_valid, a_rsp_data} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: en=%b wr=%b addr=%h data=%h rv=%b rd=%h expected all 0",
                  a_mem_en, a_mem_wr, a_mem_addr, a_mem_wdata, a_rsp_valid, a_rsp_data);
      end
      vectors++;
      if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0) begin
         miscompares++; $display("FAIL reset_release: a_ready=%b b_ready=%b b_rv=%b expected 1 1 0", a_req_ready, b_req_ready, b_rsp_valid);
      end
   endtask

   task automatic test_back_to_back();
      a_rsp_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         a_req_valid = k < 8; a_req_wr = 1'b0; a_req_addr = AW'(k);
         #1;
         if (k < 8) begin
            vectors++;
            if (a_req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready k=%0d: got %b expected 1", k, a_req_ready); end
         end
         vectors++;
         if (a_mem_en !== (k >= 1 && k <= 8)) begin miscompares++; $display("FAIL b2b_mem_en k=%0d: got %b", k, a_mem_en); end
         vectors++;
         if (k >= LAT_A && k < LAT_A + 8) begin
            if (a_rsp_valid !== 1'b1 || a_rsp_data !== W'((k - LAT_A) * 16'h11)) begin
               miscompares++; $display("FAIL b2b_rsp k=%0d: got v=%b d=%h expected v=1 d=%h", k, a_rsp_valid, a_rsp_data, W'((k - LAT_A) * 16'h11));
            end
         end else if (a_rsp_valid !== 1'b0) begin
            miscompares++; $display("FAIL b2b_idle k=%0d: got v=%b expected 0", k, a_rsp_valid);
         end
      end
      a_req_valid = 1'b0;
   endtask

   task automatic test_write_read();
      @(negedge clk);
      a_req_valid = 1'b1; a_req_wr = 1'b1; a_req_addr = 5'd5; a_req_data = 16'hBEEF; a_rsp_ready = 1'b1;
      #1;
      vectors++;
      if (a_req_ready !== 1'b1) begin miscompares++; $display("FAIL wr_ready: got %b expected 1", a_req_ready); end
      @(negedge clk); a_req_wr = 1'b0; #1;
      vectors++;
      if (a_mem_en !== 1'b1 || a_mem_wr !== 1'b1 || a_mem_addr !== 5'd5 || a_mem_wdata !== 16'hBEEF) begin
         miscompares++; $display("FAIL wr_issue: en=%b wr=%b addr=%h data=%h expected 1 1 05 beef", a_mem_en, a_mem_wr, a_mem_addr, a_mem_wdata);
      end
      @(negedge clk); a_req_valid = 1'b0; #1;
      vectors++;
      if (a_mem_en !== 1'b1 || a_mem_wr !== 1'b0 || a_mem_addr !== 5'd5) begin
         miscompares++; $display("FAIL rd_issue: en=%b wr=%b addr=%h expected 1 0 05", a_mem_en, a_mem_wr, a_mem_addr);
      end
      @(negedge clk); #1;
      vectors++;
      if (a_mem_en !== 1'b0 || a_rsp_valid !== WRACK || (a_rsp_valid && a_rsp_data !== 16'h0055)) begin
         miscompares++; $display("FAIL wr_ack: en=%b v=%b d=%h expected en=0 v=%b d=0055", a_mem_en, a_rsp_valid, a_rsp_data, WRACK);
      end
      @(negedge clk); #1;
      vectors++;
      if (a_rsp_valid !== 1'b1 || a_rsp_data !== 16'hBEEF) begin
         miscompares++; $display("FAIL rd_after_wr: got v=%b d=%h expected v=1 d=beef", a_rsp_valid, a_rsp_data);
      end
      @(negedge clk); #1;
      vectors++;
      if (a_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL wr_rd_drain: got v=%b expected 0", a_rsp_valid); end
   endtask

   task automatic test_backpressure();
      int acc = 0;
      a_rsp_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         a_req_valid = 1'b1; a_req_wr = 1'b0; a_req_addr = AW'(acc);
         #1;
         if (a_req_ready) acc++;
      end
      vectors++;
      if (acc !== 4 || a_req_ready !== 1'b0) begin
         miscompares++; $display("FAIL bp_accept: accepted=%0d ready=%b expected 4 0", acc, a_req_ready);
      end
      vectors++;
      if (a_rsp_valid !== 1'b1 || a_rsp_data !== 16'h0000) begin
         miscompares++; $display("FAIL bp_hold: got v=%b d=%h expected v=1 d=0000", a_rsp_valid, a_rsp_data);
      end
      @(negedge clk); a_req_valid = 1'b0; a_rsp_ready = 1'b1; #1;
      vectors++;
      if (a_rsp_valid !== 1'b1 || a_rsp_data !== 16'h0000 || a_req_ready !== 1'b0) begin
         miscompares++; $display("FAIL bp_drain0: v=%b d=%h ready=%b expected 1 0000 0", a_rsp_valid, a_rsp_data, a_req_ready);
      end
      for (int j = 1; j < 4; j++) begin
         @(negedge clk); #1;
         vectors++;
         if (a_rsp_valid !== 1'b1 || a_rsp_data !== W'(j * 16'h11) || (j == 1 && a_req_ready !== 1'b1)) begin
            miscompares++; $display("FAIL bp_drain%0d: v=%b d=%h ready=%b expected d=%h", j, a_rsp_valid, a_rsp_data, a_req_ready, W'(j * 16'h11));
         end
      end
      @(negedge clk); #1;
      vectors++;
      if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
         miscompares++; $display("FAIL bp_empty: v=%b ready=%b expected 0 1", a_rsp_valid, a_req_ready);
      end
   endtask

   task automatic test_mid_reset();
      a_rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         a_req_valid = 1'b1; a_req_wr = 1'b0; a_req_addr = AW'(k == 0 ? 6 : (k == 1 ? 7 : 1));
         #1;
         vectors++;
         if (a_req_ready !== 1'b1) begin miscompares++; $display("FAIL mr_ready k=%0d: got %b expected 1", k, a_req_ready); end
      end
      @(negedge clk); a_req_valid = 1'b0; rst = 1'b1; #1;
      vectors++;
      if (a_req_ready !== 1'b0) begin miscompares++; $display("FAIL mr_ready_in_rst: got %b expected 0", a_req_ready); end
      @(negedge clk); rst = 1'b0; a_rsp_ready = 1'b1; #1;
      vectors++;
      if (a_rsp_valid !== 1'b0 || a_mem_en !== 1'b0 || a_rsp_data !== 16'h0000) begin
         miscompares++; $display("FAIL mr_cleared: v=%b en=%b d=%h expected 0 0 0000", a_rsp_valid, a_mem_en, a_rsp_data);
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); #1;
         vectors++;
         if (a_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mr_stale k=%0d: got v=%b d=%h expected v=0", k, a_rsp_valid, a_rsp_data); end
      end
      @(negedge clk); a_req_valid = 1'b1; a_req_addr = 5'd2; #1;
      @(negedge clk); a_req_valid = 1'b0; #1;
      @(negedge clk); #1;
      vectors++;
      if (a_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mr_early: got v=%b expected 0", a_rsp_valid); end
      @(negedge clk); #1;
      vectors++;
      if (a_rsp_valid !== 1'b1 || a_rsp_data !== 16'h0022) begin
         miscompares++; $display("FAIL mr_post_read: got v=%b d=%h expected v=1 d=0022", a_rsp_valid, a_rsp_data);
      end
   endtask

   task automatic test_wrack();
      @(negedge clk);
      a_req_valid = 1'b1; a_req_wr = 1'b1; a_req_addr = 5'd13; a_req_data = 16'h1234; a_rsp_ready = 1'b1;
      @(negedge clk); a_req_wr = 1'b0;
      @(negedge clk); a_req_valid = 1'b0; #1;
      vectors++;
      if (a_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL wrack_early: got v=%b expected 0", a_rsp_valid); end
      @(negedge clk); #1;
      vectors++;
      if (a_rsp_valid !== WRACK || (a_rsp_valid && a_rsp_data !== 16'hAAAA)) begin
         miscompares++; $display("FAIL wrack_rsp: got v=%b d=%h expected v=%b d=aaaa", a_rsp_valid, a_rsp_data, WRACK);
      end
      @(negedge clk); #1;
      vectors++;
      if (a_rsp_valid !== 1'b1 || a_rsp_data !== 16'h1234) begin
         miscompares++; $display("FAIL wrack_read: got v=%b d=%h expected v=1 d=1234", a_rsp_valid, a_rsp_data);
      end
      @(negedge clk); #1;
      vectors++;
      if (a_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL wrack_extra: got v=%b expected 0", a_rsp_valid); end
   endtask

   task automatic test_random();
      logic [W-1:0] sb [$];
      logic [W-1:0] exp;
      int cnt = 0;
      for (int i = 0; i < L; i++) shadow_b[i] = init_b(i);
      for (int k = 0; k < 10040; k++) begin
         @(negedge clk);
         b_req_valid = k < 10000 && $urandom_range(0, 1) == 1;
         b_req_wr = $urandom_range(0, 3) == 0;
         b_req_addr = AW'($urandom);
         b_req_data = W'($urandom);
         b_rsp_ready = k >= 10000 || $urandom_range(0, 3) != 0;
         #1;
         vectors++;
         if (b_req_ready !== (cnt < 5)) begin
            miscompares++; $display("FAIL rnd_credit k=%0d: ready=%b outstanding=%0d", k, b_req_ready, cnt);
         end
         if (b_rsp_valid && b_rsp_ready) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++; $display("FAIL rnd_unexpected k=%0d: got d=%h with nothing outstanding", k, b_rsp_data);
            end else begin
               exp = sb.pop_front();
               cnt--;
               if (b_rsp_data !== exp) begin miscompares++; $display("FAIL rnd_data k=%0d: got %h expected %h", k, b_rsp_data, exp); end
            end
         end
         if (b_req_valid && b_req_ready) begin
            if (!b_req_wr || WRACK) begin
               sb.push_back(shadow_b[b_req_addr]);
               cnt++;
            end
            if (b_req_wr) shadow_b[b_req_addr] = b_req_data;
         end
      end
      vectors++;
      if (sb.size() != 0 || b_rsp_valid !== 1'b0) begin
         miscompares++; $display("FAIL rnd_drain: %0d responses missing, v=%b", sb.size(), b_rsp_valid);
      end
      b_req_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_write_read();
      test_backpressure();
      test_mid_reset();
      test_wrack();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
